// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor: direction counter
// encoding, BTB FSM states and table width helpers.
package bp_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_WEAK_T = 2'b10;
    localparam ctr_t CTR_MAX    = 2'b11;
    localparam ctr_t CTR_MIN    = 2'b00;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } btb_state_e;

    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Tag sits directly above the word-aligned index bits.
    function automatic int btb_tag_lsb(input int idx_w);
        return idx_w + 2;
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state: up on taken, down on not
// taken, pinned at CTR_MAX / CTR_MIN.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_t ctr_i,
    input  logic taken_i,
    output ctr_t ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != CTR_MAX) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != CTR_MIN) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Tagged BTB with 2-bit direction counters. Valid bits are cleared by a
// one-entry-per-cycle sweep after reset/flush, so the table needs no async clear.
module btb_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 128,
    parameter int TAG_W   = 8,
    parameter int PC_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_f,
    input  logic [PC_W-1:0] pc_plus4_f,
    output logic [PC_W-1:0] npc_f,
    output logic            hit_f,
    output logic            pred_taken_f,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_mispred,
    input  logic            flush,
    output logic            init_done,
    output logic [31:0]     mispred_cnt
);

    localparam int IDX_W   = btb_idx_w(ENTRIES);
    localparam int TAG_LSB = btb_tag_lsb(IDX_W);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [PC_W-1:0]   target_q [ENTRIES];
    ctr_t              ctr_q    [ENTRIES];

    btb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic [31:0]       mispred_cnt_q, mispred_cnt_d;
    logic              sweep_en, run;

    logic [IDX_W-1:0]  f_idx, u_idx;
    logic [TAG_W-1:0]  f_tag, u_tag;
    logic              u_hit, train_en;
    ctr_t              ctr_nxt;
    logic              unused_pc;

    assign f_idx = pc_f[IDX_W+1:2];
    assign f_tag = pc_f[TAG_LSB+TAG_W-1:TAG_LSB];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[TAG_LSB+TAG_W-1:TAG_LSB];
    assign unused_pc = ^{pc_f, upd_pc};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            INIT: begin
                if (flush)            init_idx_d = '0;
                else if (&init_idx_q) state_d    = RUN;
                else                  init_idx_d = init_idx_q + 1'b1;
            end
            RUN: begin
                if (flush) begin
                    state_d    = INIT;
                    init_idx_d = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        run       = (state_q == RUN);
        sweep_en  = (state_q == INIT);
        init_done = run;
    end

    // Mispredicts are counted in every state, independent of flush.
    assign mispred_cnt_d = (upd_valid && upd_mispred && (mispred_cnt_q != 32'hFFFF_FFFF))
                         ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
    assign mispred_cnt   = mispred_cnt_q;

    assign hit_f        = run && valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign pred_taken_f = hit_f && ctr_q[f_idx][1];
    assign npc_f        = pred_taken_f ? target_q[f_idx] : pc_plus4_f;

    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign train_en = run && upd_valid && !flush;

    bp_sat_counter u_ctr (
        .ctr_i   (ctr_q[u_idx]),
        .taken_i (upd_taken),
        .ctr_o   (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (sweep_en) begin
            valid_q[init_idx_q] <= 1'b0;
        end else if (train_en) begin
            if (u_hit) begin
                ctr_q[u_idx] <= ctr_nxt;
                if (upd_taken) target_q[u_idx] <= upd_target;
            end else if (upd_taken) begin
                valid_q[u_idx]  <= 1'b1;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= upd_target;
                ctr_q[u_idx]    <= CTR_WEAK_T;
            end
        end
    end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: expected lookups are queued as stimulus is
// driven and popped when the outputs are sampled mid-cycle.
module tb_btb_predictor;

    logic        clk, rst;
    logic [31:0] pc_f, pc_plus4_f, npc_f;
    logic        hit_f, pred_taken_f;
    logic        upd_valid, upd_taken, upd_mispred, flush;
    logic [31:0] upd_pc, upd_target;
    logic        init_done;
    logic [31:0] mispred_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic        hit;
        logic        pt;
        logic [31:0] npc;
    } exp_t;

    exp_t exp_q[$];

    btb_predictor #(.ENTRIES(128), .TAG_W(8), .PC_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_f         (pc_f),
        .pc_plus4_f   (pc_plus4_f),
        .npc_f        (npc_f),
        .hit_f        (hit_f),
        .pred_taken_f (pred_taken_f),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .upd_mispred  (upd_mispred),
        .flush        (flush),
        .init_done    (init_done),
        .mispred_cnt  (mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic expect_lookup(input string name, input logic h, input logic p, input logic [31:0] n);
        exp_t e;
        e.name = name; e.hit = h; e.pt = p; e.npc = n;
        exp_q.push_back(e);
    endtask

    task automatic check_lookup();
        exp_t e;
        #1;
        n_assert++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.name, "_hit"}, {31'd0, hit_f}, {31'd0, e.hit});
            chk({e.name, "_pt"},  {31'd0, pred_taken_f}, {31'd0, e.pt});
            chk({e.name, "_npc"}, npc_f, e.npc);
        end
    endtask

    task automatic set_pc(input logic [31:0] p);
        pc_f       = p;
        pc_plus4_f = p + 32'd4;
    endtask

    task automatic upd(input logic [31:0] p, input logic tk, input logic [31:0] tgt, input logic mp);
        upd_valid   = 1'b1;
        upd_pc      = p;
        upd_taken   = tk;
        upd_target  = tgt;
        upd_mispred = mp;
    endtask

    task automatic idle();
        upd_valid   = 1'b0;
        upd_taken   = 1'b0;
        upd_mispred = 1'b0;
        upd_pc      = '0;
        upd_target  = '0;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0;
        idle();
        set_pc(32'h100);
        repeat (3) @(negedge clk);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_mispred", mispred_cnt, 32'd0);
        expect_lookup("rst_lookup", 1'b0, 1'b0, 32'h104); check_lookup();

        // Release away from the edge; sweep occupies the next 128 edges.
        rst = 1'b1;
        for (int i = 1; i <= 127; i++) begin
            @(negedge clk);
            expect_lookup("sweep_lookup", 1'b0, 1'b0, 32'h104); check_lookup();
            if (i == 127) chk("init_done_127", {31'd0, init_done}, 32'd0);
        end
        @(negedge clk);
        chk("init_done_128", {31'd0, init_done}, 32'd1);
        expect_lookup("run_empty", 1'b0, 1'b0, 32'h104); check_lookup();

        // Allocate 0x100 -> 0x400; same-cycle lookup still misses.
        upd(32'h100, 1'b1, 32'h400, 1'b0);
        expect_lookup("alloc_same_cycle", 1'b0, 1'b0, 32'h104); check_lookup();
        @(negedge clk); idle();
        expect_lookup("alloc_visible", 1'b1, 1'b1, 32'h400); check_lookup();

        // ctr 2 -> 1 -> 0 -> 1
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        expect_lookup("ctr_1", 1'b1, 1'b0, 32'h104); check_lookup();
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        expect_lookup("ctr_0", 1'b1, 1'b0, 32'h104); check_lookup();
        upd(32'h100, 1'b1, 32'h400, 1'b0);
        @(negedge clk); idle();
        expect_lookup("ctr_0_to_1", 1'b1, 1'b0, 32'h104); check_lookup();

        // 0x10100: same index, tag bit 16 differs -> miss.
        set_pc(32'h10100);
        expect_lookup("alias_tag_miss", 1'b0, 1'b0, 32'h10104); check_lookup();
        // 0x20100: bit 17 lies above the stored tag, so it aliases onto 0x100.
        set_pc(32'h20100);
        expect_lookup("alias_above_tag", 1'b1, 1'b0, 32'h20104); check_lookup();

        // Same-edge lookup/update, no bypass.
        set_pc(32'h200);
        upd(32'h200, 1'b1, 32'h800, 1'b0);
        expect_lookup("same_edge_pre", 1'b0, 1'b0, 32'h204); check_lookup();
        @(negedge clk); idle();
        expect_lookup("same_edge_post", 1'b1, 1'b1, 32'h800); check_lookup();

        // Saturate at 3: 2->3->3, then not-taken leaves 2 (still taken).
        upd(32'h200, 1'b1, 32'h800, 1'b0);
        @(negedge clk);
        upd(32'h200, 1'b1, 32'h800, 1'b0);
        @(negedge clk);
        upd(32'h200, 1'b0, 32'h0, 1'b0);
        @(negedge clk); idle();
        expect_lookup("sat_top", 1'b1, 1'b1, 32'h800); check_lookup();

        // Not-taken misses with mispredict: counted, never allocated.
        set_pc(32'h300);
        upd(32'h300, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        upd(32'h300, 1'b0, 32'h0, 1'b1);
        @(negedge clk); idle();
        expect_lookup("nt_no_alloc", 1'b0, 1'b0, 32'h304); check_lookup();
        chk("mispred_2", mispred_cnt, 32'd2);

        // Flush with a same-cycle update: update dropped.
        set_pc(32'h200);
        flush = 1'b1;
        upd(32'h300, 1'b1, 32'h900, 1'b0);
        expect_lookup("pre_flush", 1'b1, 1'b1, 32'h800); check_lookup();
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            if (i == 0) begin
                flush = 1'b0;
                upd(32'h300, 1'b1, 32'h900, 1'b1);
            end else begin
                idle();
            end
            expect_lookup("flush_sweep", 1'b0, 1'b0, 32'h204); check_lookup();
            chk("flush_init_done", {31'd0, init_done}, 32'd0);
        end
        @(negedge clk);
        chk("flush_done", {31'd0, init_done}, 32'd1);
        expect_lookup("post_flush_200", 1'b0, 1'b0, 32'h204); check_lookup();
        set_pc(32'h300);
        expect_lookup("post_flush_300", 1'b0, 1'b0, 32'h304); check_lookup();
        set_pc(32'h100);
        expect_lookup("post_flush_100", 1'b0, 1'b0, 32'h104); check_lookup();
        chk("mispred_3", mispred_cnt, 32'd3);

        // Reset in RUN aborts at once and clears the counter.
        upd(32'h100, 1'b1, 32'h400, 1'b0);
        @(negedge clk); idle();
        expect_lookup("pre_reset", 1'b1, 1'b1, 32'h400); check_lookup();
        rst = 1'b0;
        expect_lookup("reset_run", 1'b0, 1'b0, 32'h104); check_lookup();
        chk("reset_run_init_done", {31'd0, init_done}, 32'd0);
        chk("reset_run_mispred", mispred_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
